// File: rtl/pingpong_pkg.sv
// Shared types for the ping-pong sample buffer: FSM states and bank selector.
package pingpong_pkg;

    typedef enum logic {W_FILL, W_FULL} wr_state_t;
    typedef enum logic {R_EMPTY, R_READING} rd_state_t;
    typedef enum logic {BANK_A, BANK_B} bank_t;

    function automatic bank_t other_bank(input bank_t b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage

// File: rtl/pingpong_sample_buffer_if.sv
// Sample-in / block-out bus of the ping-pong buffer; slave is the buffer, master the
// front end plus consumer.
interface pingpong_sample_buffer_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] sample_i;
    logic                    sample_valid_i;
    logic                    buffer_ready_o;
    logic                    read_enable_o;
    logic [SAMPLE_WIDTH-1:0] ram_sample_o;
    logic                    read_ack_i;
    logic                    overrun_o;
    logic                    wr_bank_o;

    modport master (
        output sample_i, sample_valid_i, read_ack_i,
        input  buffer_ready_o, read_enable_o, ram_sample_o, overrun_o, wr_bank_o
    );

    modport slave (
        input  sample_i, sample_valid_i, read_ack_i,
        output buffer_ready_o, read_enable_o, ram_sample_o, overrun_o, wr_bank_o
    );
endinterface

// File: rtl/sp_ram_bank.sv
// Single-port sample RAM with one-cycle synchronous read.
module sp_ram_bank #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DEPTH        = 256,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [SAMPLE_WIDTH-1:0] wdata,
    output logic [SAMPLE_WIDTH-1:0] rdata
);
    logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/pingpong_sample_buffer.sv
// Two-bank ping-pong sample store: one bank fills at audio rate while the other,
// full bank is drained by a consumer over the ready/enable/ack handshake.
module pingpong_sample_buffer
    import pingpong_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DEPTH        = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pingpong_sample_buffer_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    wr_state_t         wr_state, wr_state_n;
    rd_state_t         rd_state, rd_state_n;
    bank_t             wr_bank, wr_bank_n, rd_bank;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, rd_addr;
    logic              wr_we, wr_last, rd_ack, rd_last, swap;
    logic              buffer_ready_q, overrun_q, use_shadow_q;
    logic [SAMPLE_WIDTH-1:0] word0_q;

    logic [1:0]                    wr_sel, bank_we;
    logic [1:0][ADDR_W-1:0]        bank_addr;
    logic [1:0][SAMPLE_WIDTH-1:0]  bank_rdata;

    always_comb begin
        wr_state_n = wr_state;
        rd_state_n = rd_state;
        wr_bank_n  = wr_bank;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        rd_addr    = rd_ptr;

        wr_we   = (wr_state == W_FILL) && bus.sample_valid_i;
        wr_last = wr_we && (wr_ptr == LAST);
        rd_ack  = (rd_state == R_READING) && bus.read_ack_i;
        rd_last = rd_ack && (rd_ptr == LAST);
        swap    = ((wr_state == W_FULL) || wr_last) && ((rd_state == R_EMPTY) || rd_last);

        if (wr_we) begin
            wr_ptr_n = wr_ptr + 1'b1;
            if (wr_last) wr_state_n = W_FULL;
        end
        // Prefetch the next word on ack so back-to-back acks see no bubble.
        if (rd_ack) begin
            rd_ptr_n = rd_ptr + 1'b1;
            rd_addr  = rd_ptr + 1'b1;
            if (rd_last) rd_state_n = R_EMPTY;
        end
        if (swap) begin
            wr_bank_n  = other_bank(wr_bank);
            wr_ptr_n   = '0;
            rd_ptr_n   = '0;
            rd_addr    = '0;
            wr_state_n = W_FILL;
            rd_state_n = R_READING;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state       <= W_FILL;
            rd_state       <= R_EMPTY;
            wr_bank        <= BANK_A;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            buffer_ready_q <= 1'b0;
            overrun_q      <= 1'b0;
            use_shadow_q   <= 1'b0;
        end else begin
            wr_state       <= wr_state_n;
            rd_state       <= rd_state_n;
            wr_bank        <= wr_bank_n;
            wr_ptr         <= wr_ptr_n;
            rd_ptr         <= rd_ptr_n;
            buffer_ready_q <= swap;
            overrun_q      <= (wr_state == W_FULL) && bus.sample_valid_i;
            use_shadow_q   <= swap;
        end
    end

    // In the swap cycle the new read bank may still be taking its last write, so its
    // single port cannot also fetch word 0; a copy of word 0 is kept and shown at T+1.
    always_ff @(posedge clk_i) begin
        if (wr_we && (wr_ptr == '0)) word0_q <= bus.sample_i;
    end

    assign rd_bank = other_bank(wr_bank);
    assign wr_sel  = {wr_bank == BANK_B, wr_bank == BANK_A};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b]   = wr_we & wr_sel[b];
        assign bank_addr[b] = wr_sel[b] ? wr_ptr : rd_addr;

        sp_ram_bank #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .DEPTH(DEPTH)) u_bank (
            .clk_i (clk_i),
            .we    (bank_we[b]),
            .addr  (bank_addr[b]),
            .wdata (bus.sample_i),
            .rdata (bank_rdata[b])
        );
    end

    assign bus.buffer_ready_o = buffer_ready_q;
    assign bus.read_enable_o  = (rd_state == R_READING);
    assign bus.overrun_o      = overrun_q;
    assign bus.wr_bank_o      = wr_bank;
    assign bus.ram_sample_o   = use_shadow_q ? word0_q
                              : (rd_bank == BANK_B) ? bank_rdata[1] : bank_rdata[0];
endmodule

// File: tb/tb_pingpong_sample_buffer.sv
// Bench: cycle table on a DEPTH=4 buffer, then a scoreboarded random stream on DEPTH=256.
module tb_pingpong_sample_buffer;

    logic clk = 1'b0;
    logic rst4 = 1'b1;
    logic rst256 = 1'b1;
    always #5 clk = ~clk;

    pingpong_sample_buffer_if #(.SAMPLE_WIDTH(16)) bus4 ();
    pingpong_sample_buffer_if #(.SAMPLE_WIDTH(16)) bus256 ();

    pingpong_sample_buffer #(.SAMPLE_WIDTH(16), .DEPTH(4)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst4),
        .bus   (bus4)
    );

    pingpong_sample_buffer #(.SAMPLE_WIDTH(16), .DEPTH(256)) u_dut256 (
        .clk_i (clk),
        .rst_i (rst256),
        .bus   (bus256)
    );

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic [15:0] smp;
        logic        ack;
        logic        br;
        logic        re;
        logic        ov;
        logic        wb;
        logic        chk;
        logic [15:0] dat;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic rst, input logic vld, input logic [15:0] smp, input logic ack,
                       input logic br, input logic re, input logic ov, input logic wb,
                       input logic chk, input logic [15:0] dat);
        vec_t v;
        v = '{rst: rst, vld: vld, smp: smp, ack: ack, br: br, re: re, ov: ov, wb: wb,
              chk: chk, dat: dat};
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] sbq[$];
        logic [15:0] exp_s;
        logic        ack;
        int          pushed, popped, ovr, cyc;
        localparam int N6 = 768;

        // rst vld smp ack | br re ov wb chk dat
        // 1/2: fill A with 1..4, swap, then ack held high from buffer_ready+1
        add(0,1, 1,0, 0,0,0,0, 0, 0);
        add(0,1, 2,0, 0,0,0,0, 0, 0);
        add(0,1, 3,0, 0,0,0,0, 0, 0);
        add(0,1, 4,0, 1,1,0,1, 1, 1);
        add(0,0, 0,0, 0,1,0,1, 1, 1);
        add(0,0, 0,1, 0,1,0,1, 1, 2);
        add(0,0, 0,1, 0,1,0,1, 1, 3);
        add(0,0, 0,1, 0,1,0,1, 1, 4);
        add(0,0, 0,1, 0,0,0,1, 0, 0);
        add(0,0, 0,1, 0,0,0,1, 0, 0);
        // 3: fresh fill, stalled reader, overruns, then drain triggers swap
        add(1,0, 0,0, 0,0,0,0, 0, 0);
        add(0,1,11,0, 0,0,0,0, 0, 0);
        add(0,1,12,0, 0,0,0,0, 0, 0);
        add(0,1,13,0, 0,0,0,0, 0, 0);
        add(0,1,14,0, 1,1,0,1, 1,11);
        add(0,1,21,0, 0,1,0,1, 1,11);
        add(0,1,22,0, 0,1,0,1, 1,11);
        add(0,1,23,0, 0,1,0,1, 1,11);
        add(0,1,24,0, 0,1,0,1, 1,11);
        add(0,1,25,0, 0,1,1,1, 1,11);
        add(0,1,26,0, 0,1,1,1, 1,11);
        add(0,0, 0,1, 0,1,0,1, 1,12);
        add(0,0, 0,1, 0,1,0,1, 1,13);
        add(0,0, 0,1, 0,1,0,1, 1,14);
        add(0,0, 0,1, 1,1,0,0, 1,21);
        // 4: last write (8) coincides with last ack
        add(0,1, 5,0, 0,1,0,0, 1,21);
        add(0,1, 6,1, 0,1,0,0, 1,22);
        add(0,0, 0,1, 0,1,0,0, 1,23);
        add(0,1, 7,1, 0,1,0,0, 1,24);
        add(0,1, 8,1, 1,1,0,1, 1, 5);
        add(0,0, 0,0, 0,1,0,1, 1, 5);
        // 5: reset at rd_ptr=2, then a fresh bank is required
        add(0,0, 0,1, 0,1,0,1, 1, 6);
        add(0,0, 0,1, 0,1,0,1, 1, 7);
        add(1,0, 0,0, 0,0,0,0, 0, 0);
        add(0,1,31,0, 0,0,0,0, 0, 0);
        add(0,1,32,0, 0,0,0,0, 0, 0);
        add(0,1,33,0, 0,0,0,0, 0, 0);
        add(0,1,34,0, 1,1,0,1, 1,31);
        add(0,0, 0,0, 0,1,0,1, 1,31);

        bus4.sample_i = '0;   bus4.sample_valid_i = 1'b0;   bus4.read_ack_i = 1'b0;
        bus256.sample_i = '0; bus256.sample_valid_i = 1'b0; bus256.read_ack_i = 1'b0;

        repeat (3) @(negedge clk);
        check("reset br", 32'(bus4.buffer_ready_o), 0);
        check("reset re", 32'(bus4.read_enable_o), 0);
        check("reset ov", 32'(bus4.overrun_o), 0);
        check("reset wb", 32'(bus4.wr_bank_o), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst4                = tbl[i].rst;
            bus4.sample_valid_i = tbl[i].vld;
            bus4.sample_i       = tbl[i].smp;
            bus4.read_ack_i     = tbl[i].ack;
            @(negedge clk);
            check($sformatf("v%0d br", i), 32'(bus4.buffer_ready_o), 32'(tbl[i].br));
            check($sformatf("v%0d re", i), 32'(bus4.read_enable_o),  32'(tbl[i].re));
            check($sformatf("v%0d ov", i), 32'(bus4.overrun_o),      32'(tbl[i].ov));
            check($sformatf("v%0d wb", i), 32'(bus4.wr_bank_o),      32'(tbl[i].wb));
            if (tbl[i].chk)
                check($sformatf("v%0d data", i), 32'(bus4.ram_sample_o), 32'(tbl[i].dat));
        end

        // 6: DEPTH=256 stream at ~1/8 rate, consumer acking every cycle from T+2
        rst256 = 1'b0;
        pushed = 0; popped = 0; ovr = 0; cyc = 0;
        while (popped < N6 && cyc < 20000) begin
            if (bus256.overrun_o) ovr++;
            ack = bus256.read_enable_o && !bus256.buffer_ready_o;
            if (ack) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb underflow: got word %0h expected none", bus256.ram_sample_o);
                end else begin
                    exp_s = sbq.pop_front();
                    check($sformatf("sb data %0d", popped), 32'(bus256.ram_sample_o), 32'(exp_s));
                end
                popped++;
            end
            bus256.read_ack_i = ack;
            bus256.sample_valid_i = 1'b0;
            if (pushed < N6 && $urandom_range(7) == 0) begin
                bus256.sample_valid_i = 1'b1;
                bus256.sample_i = 16'($urandom);
                sbq.push_back(bus256.sample_i);
                pushed++;
            end
            @(negedge clk);
            cyc++;
        end
        check("sb words read", 32'(popped), 32'(N6));
        check("sb leftover", 32'(sbq.size()), 0);
        check("sb overruns", 32'(ovr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
